dma_xfer_scheduler: RTL and testbench

- Command-level controller for the DMA datapath.
- Accepts copy descriptors (src, dst, byte length) into a small internal queue. Launches each descriptor on the read master and write master with simultaneous start pulses, then waits for both done indications.
- Reports completion, error and status to the register/interrupt layer.
- Sits between the AXI-Lite control slave and the read/write master cores that share the data FIFO.

---
 rtl/dma_xfer_scheduler.sv | 169 ++++++++++++++++
 tb/tb_dma_xfer_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_scheduler.sv
// Descriptor queue plus launch/complete FSM for the DMA read and write masters.
// Each descriptor starts both masters together, then waits for both done pulses.
module dma_xfer_scheduler #(
    parameter int unsigned C_ADDR_WIDTH     = 32,
    parameter int unsigned C_LEN_WIDTH      = 32,
    parameter int unsigned C_QUEUE_DEPTH    = 4,
    parameter int unsigned C_TIMEOUT_CYCLES = 1048576
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [C_ADDR_WIDTH-1:0] i_cmd_src,
    input  logic [C_ADDR_WIDTH-1:0] i_cmd_dst,
    input  logic [C_LEN_WIDTH-1:0]  i_cmd_len,
    output logic                    o_rd_start,
    output logic [C_ADDR_WIDTH-1:0] o_rd_src_addr,
    output logic [C_LEN_WIDTH-1:0]  o_rd_total_len,
    input  logic                    i_rd_done,
    output logic                    o_wr_start,
    output logic [C_ADDR_WIDTH-1:0] o_wr_dst_addr,
    output logic [C_LEN_WIDTH-1:0]  o_wr_total_len,
    input  logic                    i_wr_done,
    input  logic                    i_err_clear,
    output logic                    o_busy,
    output logic                    o_irq,
    output logic                    o_err_timeout,
    output logic                    o_err_align,
    output logic [15:0]             o_done_count,
    output logic [2:0]              o_queue_level
);
    localparam int unsigned AW = $clog2(C_QUEUE_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DONE, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [C_ADDR_WIDTH-1:0] q_src [C_QUEUE_DEPTH];
    logic [C_ADDR_WIDTH-1:0] q_dst [C_QUEUE_DEPTH];
    logic [C_LEN_WIDTH-1:0]  q_len [C_QUEUE_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           level, level_nxt;
    logic                    cmd_ready;
    logic                    push, pop;
    logic                    rd_seen, wr_seen;
    logic [31:0]             wd_cnt;
    logic                    both_done, wd_expired, misaligned, len_zero;

    assign push        = i_cmd_valid && cmd_ready;
    assign o_cmd_ready = cmd_ready;
    // a done pulse in the current RUN cycle counts immediately
    assign both_done   = (rd_seen || i_rd_done) && (wr_seen || i_wr_done);
    assign wd_expired  = (C_TIMEOUT_CYCLES != 0) &&
                         (wd_cnt == 32'(C_TIMEOUT_CYCLES - 1));
    assign len_zero    = (o_rd_total_len == '0);
    assign misaligned  = (o_rd_total_len[1:0] != 2'b00) ||
                         (o_rd_src_addr[1:0] != 2'b00) ||
                         (o_wr_dst_addr[1:0] != 2'b00);

    assign o_rd_start    = (state == S_START);
    assign o_wr_start    = (state == S_START);
    assign o_busy        = (state == S_LOAD) || (state == S_START) ||
                           (state == S_RUN)  || (state == S_DONE);
    assign o_queue_level = 3'(level);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE:  if (level != '0) begin
                         pop       = 1'b1;
                         state_nxt = S_LOAD;
                     end
            S_LOAD:  if (len_zero)        state_nxt = S_DONE;
                     else if (misaligned) state_nxt = S_IDLE;
                     else                 state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN:   if (both_done)       state_nxt = S_DONE;
                     else if (wd_expired) state_nxt = S_HALT;
            S_DONE:  state_nxt = S_IDLE;
            S_HALT:  if (i_err_clear)     state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + 1'b1;
        else if (!push && pop) level_nxt = level - 1'b1;
    end

    // queue storage needs no reset; the pointers define validity
    always_ff @(posedge M_AXI_ACLK) begin
        if (push) begin
            q_src[wr_ptr] <= i_cmd_src;
            q_dst[wr_ptr] <= i_cmd_dst;
            q_len[wr_ptr] <= i_cmd_len;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            cmd_ready      <= 1'b0;
            rd_seen        <= 1'b0;
            wr_seen        <= 1'b0;
            wd_cnt         <= '0;
            o_rd_src_addr  <= '0;
            o_rd_total_len <= '0;
            o_wr_dst_addr  <= '0;
            o_wr_total_len <= '0;
            o_irq          <= 1'b0;
            o_err_timeout  <= 1'b0;
            o_err_align    <= 1'b0;
            o_done_count   <= '0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            cmd_ready <= (level_nxt < LW'(C_QUEUE_DEPTH));
            o_irq     <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr         <= rd_ptr + 1'b1;
                o_rd_src_addr  <= q_src[rd_ptr];
                o_rd_total_len <= q_len[rd_ptr];
                o_wr_dst_addr  <= q_dst[rd_ptr];
                o_wr_total_len <= q_len[rd_ptr];
            end

            if (i_err_clear) begin
                o_err_align <= 1'b0;
                if (state == S_HALT) o_err_timeout <= 1'b0;
            end

            case (state)
                S_LOAD: if (!len_zero && misaligned) begin
                            o_err_align <= 1'b1;
                            o_irq       <= 1'b1;
                        end
                S_START: begin
                    rd_seen <= i_rd_done;
                    wr_seen <= i_wr_done;
                    wd_cnt  <= '0;
                end
                S_RUN: begin
                    rd_seen <= rd_seen || i_rd_done;
                    wr_seen <= wr_seen || i_wr_done;
                    wd_cnt  <= wd_cnt + 1'b1;
                    if (!both_done && wd_expired) begin
                        o_err_timeout <= 1'b1;
                        o_irq         <= 1'b1;
                    end
                end
                S_DONE: begin
                    o_irq        <= 1'b1;
                    o_done_count <= o_done_count + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_xfer_scheduler.sv
// Scoreboard bench: the push task predicts starts and irqs from the descriptor
// rules; a negedge monitor pops and compares whenever the DUT shows them.
module tb_dma_xfer_scheduler;
    localparam int TO = 100;

    typedef struct { logic [31:0] src; logic [31:0] dst; logic [31:0] len; } desc_t;
    typedef struct { int kind; int cnt; } irq_t;          // kind: 0 done, 1 align, 2 timeout
    typedef struct { int rdd; int wrd; bit hang; } resp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_cmd_valid = 1'b0, i_rd_done = 1'b0, i_wr_done = 1'b0, i_err_clear = 1'b0;
    logic [31:0] i_cmd_src = '0, i_cmd_dst = '0, i_cmd_len = '0;
    logic        o_cmd_ready, o_rd_start, o_wr_start, o_busy, o_irq, o_err_timeout, o_err_align;
    logic [31:0] o_rd_src_addr, o_rd_total_len, o_wr_dst_addr, o_wr_total_len;
    logic [15:0] o_done_count;
    logic [2:0]  o_queue_level;

    desc_t exp_start[$];
    irq_t  exp_irq[$];
    resp_t resp_q[$];
    desc_t mon_d;
    irq_t  mon_i;
    resp_t cur;
    int    n_checks = 0, n_fail = 0, mdl_done = 0;
    int    rd_cnt = -1, wr_cnt = -1;
    bit    stray_rd = 1'b0;

    dma_xfer_scheduler #(.C_TIMEOUT_CYCLES(TO)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_src(i_cmd_src), .i_cmd_dst(i_cmd_dst), .i_cmd_len(i_cmd_len),
        .o_rd_start(o_rd_start), .o_rd_src_addr(o_rd_src_addr), .o_rd_total_len(o_rd_total_len),
        .i_rd_done(i_rd_done),
        .o_wr_start(o_wr_start), .o_wr_dst_addr(o_wr_dst_addr), .o_wr_total_len(o_wr_total_len),
        .i_wr_done(i_wr_done), .i_err_clear(i_err_clear),
        .o_busy(o_busy), .o_irq(o_irq), .o_err_timeout(o_err_timeout), .o_err_align(o_err_align),
        .o_done_count(o_done_count), .o_queue_level(o_queue_level)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rd_start || o_wr_start) begin
                check("start_pair", {o_rd_start, o_wr_start}, 2'b11);
                if (exp_start.size() == 0) check("unexpected_start", 1, 0);
                else begin
                    mon_d = exp_start.pop_front();
                    check("rd_src", o_rd_src_addr, mon_d.src);
                    check("wr_dst", o_wr_dst_addr, mon_d.dst);
                    check("rd_len", o_rd_total_len, mon_d.len);
                    check("wr_len", o_wr_total_len, mon_d.len);
                end
            end
            if (o_irq) begin
                if (exp_irq.size() == 0) check("unexpected_irq", 1, 0);
                else begin
                    mon_i = exp_irq.pop_front();
                    check("irq_done_count", o_done_count, 16'(mon_i.cnt));
                    if (mon_i.kind == 1) check("irq_align_flag", o_err_align, 1);
                    if (mon_i.kind == 2) check("irq_timeout_flag", o_err_timeout, 1);
                    if (mon_i.kind == 0) check("irq_busy_clear", o_busy, 0);
                end
            end
        end
    end

    // read/write master responder: done pulses after per-descriptor delays
    always @(negedge clk) begin
        i_rd_done = stray_rd;
        i_wr_done = 1'b0;
        if (!rst_n) begin
            rd_cnt = -1;
            wr_cnt = -1;
        end else begin
            if (rd_cnt > 0) begin rd_cnt--; if (rd_cnt == 0) begin i_rd_done = 1'b1; rd_cnt = -1; end end
            if (wr_cnt > 0) begin wr_cnt--; if (wr_cnt == 0) begin i_wr_done = 1'b1; wr_cnt = -1; end end
            if (o_rd_start && resp_q.size() > 0) begin
                cur    = resp_q.pop_front();
                rd_cnt = cur.rdd;
                wr_cnt = cur.hang ? -1 : cur.wrd;
                if (rd_cnt == 0) begin i_rd_done = 1'b1; rd_cnt = -1; end
                if (wr_cnt == 0) begin i_wr_done = 1'b1; wr_cnt = -1; end
            end
        end
    end

    task automatic push(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                        input int rdd, input int wrd, input bit hang);
        int t = 0;
        irq_t ir;
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_src = src; i_cmd_dst = dst; i_cmd_len = len;
        while (!o_cmd_ready && t < 2000) begin @(negedge clk); t++; end
        if (!o_cmd_ready) begin
            check("push_ready_timeout", 0, 1);
            i_cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        if (len == 0) begin
            mdl_done++;
            ir = '{0, mdl_done};
        end else if (len % 4 != 0 || src % 4 != 0 || dst % 4 != 0) begin
            ir = '{1, mdl_done};
        end else begin
            exp_start.push_back('{src, dst, len});
            resp_q.push_back('{rdd, wrd, hang});
            if (hang) ir = '{2, mdl_done};
            else begin mdl_done++; ir = '{0, mdl_done}; end
        end
        exp_irq.push_back(ir);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_irq.size() != 0 || o_busy || o_queue_level != 0) && t < 3000) begin
            @(negedge clk); t++;
        end
        check({name, "_drain"}, t < 3000, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {o_cmd_ready, o_rd_start, o_wr_start, o_busy, o_irq,
                               o_err_timeout, o_err_align}, 0);
        check({name, "_cnt"}, {o_done_count, o_queue_level}, 0);
        check({name, "_addr"}, o_rd_src_addr | o_wr_dst_addr | o_rd_total_len | o_wr_total_len, 0);
    endtask

    initial begin
        logic [31:0] s, d, l;
        int   r, t;
        time  tstart;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", o_cmd_ready, 1);

        // single descriptor, rd at +20, wr at +30
        push(32'h1000, 32'h2000, 64, 20, 30, 0);
        drain("single");
        check("single_count", o_done_count, 1);
        check("single_busy", o_busy, 0);

        // five back-to-back with slow masters: queue fills to depth
        for (int i = 0; i < 5; i++) push(32'h1_0000 + i * 256, 32'h2_0000 + i * 256, 32 + i * 4, 40, 45, 0);
        @(negedge clk);
        check("full_level", o_queue_level, 4);
        check("full_ready", o_cmd_ready, 0);
        drain("backpressure");
        check("backpressure_count", o_done_count, 6);

        // same-cycle, reversed order, done inside the START cycle, stray done in IDLE
        push(32'h300, 32'h400, 8, 5, 5, 0);
        push(32'h500, 32'h600, 12, 10, 3, 0);
        push(32'h700, 32'h800, 16, 0, 4, 0);
        drain("order");
        @(posedge clk); #1 stray_rd = 1'b1;
        @(posedge clk); #1 stray_rd = 1'b0;
        repeat (5) @(negedge clk);
        check("stray_idle_busy", o_busy, 0);
        check("stray_count", o_done_count, 9);

        // zero length and misaligned length
        push(32'h900, 32'hA00, 0, 1, 1, 0);
        push(32'h900, 32'hA00, 6, 1, 1, 0);
        push(32'hB00, 32'hC00, 4, 2, 2, 0);
        drain("align");
        check("align_sticky", o_err_align, 1);
        check("align_count", o_done_count, 11);
        @(negedge clk) i_err_clear = 1'b1;
        @(negedge clk) i_err_clear = 1'b0;
        check("align_cleared", {o_err_align, o_err_timeout}, 0);

        // watchdog: write done withheld
        push(32'h3000, 32'h4000, 16, 5, 0, 1);
        t = 0;
        while (!o_rd_start && t < 20) begin @(negedge clk); t++; end
        tstart = $time;
        push(32'h5000, 32'h6000, 20, 3, 6, 0);
        push(32'h7000, 32'h8000, 24, 6, 3, 0);
        t = 0;
        while (!o_err_timeout && t < 300) begin @(negedge clk); t++; end
        t = int'(($time - tstart) / 10);
        check("timeout_latency", (t >= 99 && t <= 102), 1);
        push(32'h9000, 32'hA000, 28, 4, 4, 0);
        repeat (10) @(negedge clk);
        check("halt_level", o_queue_level, 3);
        check("halt_busy", o_busy, 0);
        check("halt_err", o_err_timeout, 1);
        @(negedge clk) i_err_clear = 1'b1;
        @(negedge clk) i_err_clear = 1'b0;
        check("timeout_cleared", o_err_timeout, 0);
        drain("timeout");
        check("timeout_count", o_done_count, 14);

        // randomized mix of normal, zero-length and misaligned descriptors
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            l = 32'(4 * $urandom_range(1, 64));
            if (r == 0) l = 0;
            else if (r == 1) l = l + 32'($urandom_range(1, 3));
            else if (r == 2) s = s | 32'($urandom_range(1, 3));
            push(s, d, l, $urandom_range(0, 15), $urandom_range(0, 15), 0);
        end
        drain("random");
        check("random_count", o_done_count, 16'(mdl_done));

        // reset during RUN with two queued
        push(32'h100, 32'h200, 40, 60, 70, 0);
        push(32'h140, 32'h240, 44, 5, 5, 0);
        push(32'h180, 32'h280, 48, 5, 5, 0);
        repeat (10) @(negedge clk);
        check("pre_reset_busy", {o_busy, o_queue_level}, {1'b1, 3'd2});
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrun_reset");
        exp_start.delete(); exp_irq.delete(); resp_q.delete();
        mdl_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_midrun_reset", o_cmd_ready, 1);
        repeat (20) @(negedge clk);
        check("post_reset_quiet", {o_busy, o_done_count}, 0);
        push(32'h4400, 32'h8800, 16, 2, 3, 0);
        drain("recover");
        check("recover_count", o_done_count, 1);

        check("leftover_starts", exp_start.size(), 0);
        check("leftover_resp", resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
